global_mem_ctrl: RTL and testbench
==================================

// Module: global_mem_ctrl
// PURPOSE
//  Main-memory stage directly downstream of the vector processing block. Services its
//  load_ctrl/load_addr and write_ctrl/write_addr_main/write_data_main requests against
//  an on-chip array of CORES*BITS-wide words. Returns load data through a fixed-latency
//  pipeline. Flags out-of-range accesses.
// PARAMETERS
//  CORES        32   lanes per word
//  BITS         16   bits per lane; word width WW = CORES*BITS
//  ADDR_WIDTH   16   request address width
//  DEPTH        1024 implemented words; valid addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_WIDTH)
//  LOAD_LATENCY 2    cycles from load request to load_valid, legal range 1..8
// PORTS
//  clock        in   1          rising-edge clock
//  reset_n      in   1          synchronous active-low reset
//  load_ctrl    in   1          load request, sampled every rising edge
//  load_addr    in   ADDR_WIDTH load word address
//  write_ctrl   in   1          write request, sampled every rising edge
//  write_addr   in   ADDR_WIDTH write word address
//  write_data   in   WW         write word
//  load_data    out  WW         returned load word, held until the next return
//  load_valid   out  1          one-cycle pulse: load_data updated this cycle
//  loads_pend   out  4          loads in flight (0..LOAD_LATENCY)
//  addr_err     out  1          one-cycle pulse: an out-of-range access was sampled
//  err_sticky   out  1          set by any addr_err, cleared only by reset
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): load_data=0, load_valid=0, loads_pend=0, addr_err=0,
//    err_sticky=0. All pipeline valid bits are cleared and in-flight loads are discarded
//    (no load_valid for them). The array is not reset; its contents are retained.
//  - No backpressure: every request is accepted at the edge where it is sampled.
//    A load may be issued every cycle.
//  - Write: at the edge with write_ctrl=1 and write_addr<DEPTH, mem[write_addr] <= write_data.
//    An out-of-range write is dropped and pulses addr_err.
//  - Load: at edge t with load_ctrl=1, the array is read and the word enters stage 1 of a
//    LOAD_LATENCY-deep shift pipeline. Address >= DEPTH reads as 0 and pulses addr_err.
//    - load_valid=1 and load_data=word in the cycle after edge t+LOAD_LATENCY-1.
//      With LOAD_LATENCY=1, the response appears the cycle right after the request.
//    - Responses return in request order.
//  - Data snapshot: the load word is captured at the request edge. Writes to the same
//    address while the load is in flight do not alter it.
//  - Simultaneous load+write in one cycle are both accepted.
//    - Different addresses: independent.
//    - Same address: see CONFIGURATION.
//  - addr_err pulses at most once per cycle, even if both accesses are out of range.
//  - loads_pend = number of set pipeline valid bits. It increments on accept and
//    decrements on load_valid; both in the same cycle leave it unchanged.
//  - No latches; one always block on posedge clock holds the array and pipeline.
// CONFIGURATION
//  RAW_BYPASS_EN defined: a same-cycle load+write to the same in-range address returns
//    write_data (write-first).
//  RAW_BYPASS_EN undefined: the load returns the pre-write array contents (read-first).
//    The write still commits.
// TESTING
//  1 reset: hold reset_n=0 for 3 cycles -> all outputs 0; then write 0xA5A5.. to addr 7,
//    load addr 7 -> load_valid exactly 2 cycles after the request, data 0xA5A5..
//  2 back-to-back loads: addrs 0,1,2,3 on consecutive cycles (preloaded 10,11,12,13) ->
//    4 consecutive load_valid pulses with data 10,11,12,13; loads_pend peaks at 2.
//  3 same-cycle RAW: mem[5]=1, load+write(5,2) -> returns 2 with RAW_BYPASS_EN, else 1;
//    a subsequent load of addr 5 returns 2 in both builds.
//  4 out of range: load addr DEPTH (1024) -> load_data=0, addr_err one cycle,
//    err_sticky=1 until reset; write addr 2000 -> array unchanged.
//  5 reset mid-flight: issue load, assert reset_n=0 the next cycle -> no load_valid,
//    loads_pend=0; load after reset returns pre-reset array contents.
//  6 LOAD_LATENCY=1 and =8 builds: repeat scenario 2 -> response delay 1 and 8 cycles.

Source files
------------

// File: rtl/global_mem_ctrl.sv
// ---------------------------------------------------------------------------
// global_mem_ctrl
//   Main-memory stage behind the vector processing block. Holds DEPTH words of
//   CORES*BITS bits, services one load and one write request per cycle with no
//   backpressure, and returns load words through a fixed LOAD_LATENCY-deep
//   shift pipeline in request order. Out-of-range accesses are dropped (writes)
//   or read as zero (loads) and flagged on addr_err / err_sticky.
//
//   Build option: define RAW_BYPASS_EN for write-first behaviour on a
//   same-cycle load+write to the same in-range address; left undefined the
//   load sees the pre-write contents (read-first). The write commits either way.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   synchronous active-low reset (array contents retained)
//   load_ctrl   in   load request
//   load_addr   in   load word address
//   write_ctrl  in   write request
//   write_addr  in   write word address
//   write_data  in   write word
//   load_data   out  returned load word, held until the next return
//   load_valid  out  one-cycle pulse, load_data updated this cycle
//   loads_pend  out  loads in flight (0..LOAD_LATENCY)
//   addr_err    out  one-cycle pulse, an out-of-range access was sampled
//   err_sticky  out  set by any addr_err, cleared only by reset
// ---------------------------------------------------------------------------
module global_mem_ctrl #(
  parameter int CORES        = 32,
  parameter int BITS         = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 1024,
  parameter int LOAD_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load_ctrl,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic                    write_ctrl,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [CORES*BITS-1:0]   write_data,
  output logic [CORES*BITS-1:0]   load_data,
  output logic                    load_valid,
  output logic [3:0]              loads_pend,
  output logic                    addr_err,
  output logic                    err_sticky
);

  localparam int WW = CORES * BITS;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam int LAST = LOAD_LATENCY - 1;

  logic [WW-1:0]           mem_r [DEPTH];
  // The last pipeline stage doubles as the load_data / load_valid register.
  logic [WW-1:0]           pipe_data_r [LOAD_LATENCY];
  logic [LOAD_LATENCY-1:0] pipe_vld_r;
  logic [3:0]              pend_r;
  logic                    err_r;
  logic                    sticky_r;

  logic [WW-1:0]           src_data_s [LOAD_LATENCY];
  logic [LOAD_LATENCY-1:0] src_vld_s;
  logic [WW-1:0]           rd_word_s;
  logic                    load_in_range_s;
  logic                    write_in_range_s;
  logic                    same_addr_s;
  logic                    err_s;

  // Address range decode and error detection for the current request pair.
  always_comb begin
    load_in_range_s  = ({1'b0, load_addr}  < DEPTH_W);
    write_in_range_s = ({1'b0, write_addr} < DEPTH_W);
    same_addr_s      = (load_addr == write_addr);
    err_s            = (load_ctrl  && !load_in_range_s) ||
                       (write_ctrl && !write_in_range_s);
  end

  // Word captured at the request edge: zero when out of range, optional bypass.
  always_comb begin
    rd_word_s = '0;
    if (!load_in_range_s) begin
      rd_word_s = '0;
    end
`ifdef RAW_BYPASS_EN
    else if (write_ctrl && write_in_range_s && same_addr_s) begin
      rd_word_s = write_data;
    end
`endif
    else begin
      rd_word_s = mem_r[load_addr[IW-1:0]];
    end
  end

  // Input of every pipeline stage: stage 0 takes the new request, others shift.
  always_comb begin
    src_vld_s = '0;
    for (int k = 0; k < LOAD_LATENCY; k++) begin
      src_data_s[k] = '0;
    end
    src_vld_s[0]  = load_ctrl;
    src_data_s[0] = rd_word_s;
    for (int k = 1; k < LOAD_LATENCY; k++) begin
      src_vld_s[k]  = pipe_vld_r[k-1];
      src_data_s[k] = pipe_data_r[k-1];
    end
  end

  // Array, load pipeline, in-flight counter and error flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // Array deliberately untouched: contents survive reset.
      pipe_vld_r        <= '0;
      pipe_data_r[LAST] <= '0;
      pend_r            <= 4'd0;
      err_r             <= 1'b0;
      sticky_r          <= 1'b0;
    end else begin
      if (write_ctrl && write_in_range_s) begin
        mem_r[write_addr[IW-1:0]] <= write_data;
      end
      pipe_vld_r <= src_vld_s;
      for (int k = 0; k < LOAD_LATENCY; k++) begin
        // Final stage only moves on a real return so load_data is held.
        if ((k < LAST) || src_vld_s[k]) begin
          pipe_data_r[k] <= src_data_s[k];
        end
      end
      pend_r   <= pend_r + {3'd0, load_ctrl} - {3'd0, pipe_vld_r[LAST]};
      err_r    <= err_s;
      sticky_r <= sticky_r | err_s;
    end
  end

  assign load_data  = pipe_data_r[LAST];
  assign load_valid = pipe_vld_r[LAST];
  assign loads_pend = pend_r;
  assign addr_err   = err_r;
  assign err_sticky = sticky_r;

endmodule

// File: tb/tb_global_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_global_mem_ctrl
//   Directed bench for global_mem_ctrl. The driver pushes the expected load
//   word and the expected return cycle into a scoreboard at issue time; a
//   monitor on the falling edge pops and compares whenever load_valid is seen.
//   Change LAT (and define RAW_BYPASS_EN) to cover the other builds.
// ---------------------------------------------------------------------------
module tb_global_mem_ctrl;

  localparam int LAT   = 2;
  localparam int WW    = 512;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          load_ctrl;
  logic [AW-1:0] load_addr;
  logic          write_ctrl;
  logic [AW-1:0] write_addr;
  logic [WW-1:0] write_data;
  logic [WW-1:0] load_data;
  logic          load_valid;
  logic [3:0]    loads_pend;
  logic          addr_err;
  logic          err_sticky;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int peak_pend = 0;

  logic [WW-1:0] exp_data_q [$];
  int            exp_cyc_q  [$];

  logic [WW-1:0] pat_a5;
  logic [WW-1:0] exp_raw;

  global_mem_ctrl #(
    .CORES(32), .BITS(16), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LOAD_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .load_ctrl(load_ctrl), .load_addr(load_addr),
    .write_ctrl(write_ctrl), .write_addr(write_addr), .write_data(write_data),
    .load_data(load_data), .load_valid(load_valid), .loads_pend(loads_pend),
    .addr_err(addr_err), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every load_valid must match the oldest outstanding load.
  always @(negedge clock) begin
    logic [WW-1:0] d;
    int            c;
    if (int'(loads_pend) > peak_pend) peak_pend = int'(loads_pend);
    if (load_valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got load_valid=1 data=%0h expected no response", load_data);
      end else begin
        d = exp_data_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("load_data", load_data, d);
        check("load_latency_cycle", WW'(cyc), WW'(c));
      end
    end
  end

  // One clock of stimulus; loads register their expected word and return cycle.
  task automatic drive(input logic lc, input logic [AW-1:0] la,
                       input logic wc, input logic [AW-1:0] wa,
                       input logic [WW-1:0] wd, input logic [WW-1:0] ed);
    load_ctrl  = lc;
    load_addr  = la;
    write_ctrl = wc;
    write_addr = wa;
    write_data = wd;
    if (lc) begin
      exp_data_q.push_back(ed);
      exp_cyc_q.push_back(cyc + LAT);
    end
    @(negedge clock);
    load_ctrl  = 1'b0;
    write_ctrl = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    pat_a5     = {32{16'hA5A5}};
    reset_n    = 1'b0;
    load_ctrl  = 1'b0;
    load_addr  = '0;
    write_ctrl = 1'b0;
    write_addr = '0;
    write_data = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_load_valid", WW'(load_valid), WW'(0));
    check("rst_load_data",  load_data, WW'(0));
    check("rst_loads_pend", WW'(loads_pend), WW'(0));
    check("rst_addr_err",   WW'(addr_err), WW'(0));
    check("rst_err_sticky", WW'(err_sticky), WW'(0));
    reset_n = 1'b1;
    @(negedge clock);

    // Write then load addr 7
    drive(1'b0, 16'd0, 1'b1, 16'd7, pat_a5, '0);
    drive(1'b1, 16'd7, 1'b0, 16'd0, '0, pat_a5);
    idle(LAT + 3);
    check("load_data_hold", load_data, pat_a5);

    // Back-to-back loads of preloaded 10..13
    for (int i = 0; i < 4; i++) drive(1'b0, 16'd0, 1'b1, AW'(i), WW'(10 + i), '0);
    peak_pend = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, AW'(i), 1'b0, 16'd0, '0, WW'(10 + i));
    idle(LAT + 2);
    check("peak_loads_pend", WW'(peak_pend), WW'((LAT < 4) ? LAT : 4));
    check("idle_loads_pend", WW'(loads_pend), WW'(0));

    // Same-cycle load+write to the same address
`ifdef RAW_BYPASS_EN
    exp_raw = WW'(2);
`else
    exp_raw = WW'(1);
`endif
    drive(1'b0, 16'd0, 1'b1, 16'd5, WW'(1), '0);
    drive(1'b1, 16'd5, 1'b1, 16'd5, WW'(2), exp_raw);
    drive(1'b1, 16'd5, 1'b0, 16'd0, '0, WW'(2));
    // Different addresses in one cycle are independent
    drive(1'b1, 16'd0, 1'b1, 16'd6, WW'(66), WW'(10));
    drive(1'b1, 16'd6, 1'b0, 16'd0, '0, WW'(66));
    idle(LAT + 2);

    // Out-of-range accesses
    drive(1'b0, 16'd0, 1'b1, 16'd976, WW'(16'h0077), '0);
    drive(1'b1, 16'd1024, 1'b0, 16'd0, '0, '0);
    check("oob_load_addr_err", WW'(addr_err), WW'(1));
    check("oob_err_sticky",    WW'(err_sticky), WW'(1));
    idle(1);
    check("addr_err_pulse_end", WW'(addr_err), WW'(0));
    drive(1'b0, 16'd0, 1'b1, 16'd1023, WW'(16'h0099), '0);
    check("in_range_no_err", WW'(addr_err), WW'(0));
    drive(1'b1, 16'd1024, 1'b1, 16'd2000, {WW{1'b1}}, '0);
    check("dual_oob_addr_err", WW'(addr_err), WW'(1));
    idle(1);
    check("dual_oob_pulse_end", WW'(addr_err), WW'(0));
    drive(1'b1, 16'd976, 1'b0, 16'd0, '0, WW'(16'h0077));
    drive(1'b1, 16'd1023, 1'b0, 16'd0, '0, WW'(16'h0099));
    idle(LAT + 2);
    check("err_sticky_held", WW'(err_sticky), WW'(1));

    // Reset while a load is in flight
    drive(1'b1, 16'd7, 1'b0, 16'd0, '0, pat_a5);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    exp_data_q.delete();
    exp_cyc_q.delete();
    idle(2);
    check("midrst_loads_pend", WW'(loads_pend), WW'(0));
    check("midrst_load_valid", WW'(load_valid), WW'(0));
    check("midrst_err_sticky", WW'(err_sticky), WW'(0));
    check("midrst_load_data",  load_data, WW'(0));
    reset_n = 1'b1;
    @(negedge clock);
    drive(1'b1, 16'd7, 1'b0, 16'd0, '0, pat_a5);
    drive(1'b1, 16'd3, 1'b0, 16'd0, '0, WW'(13));
    drive(1'b1, 16'd5, 1'b0, 16'd0, '0, WW'(2));

    // Bounded drain of the scoreboard
    for (int i = 0; (i < LAT + 10) && (exp_data_q.size() != 0); i++) @(negedge clock);
    checks++;
    if (exp_data_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d outstanding loads expected 0", exp_data_q.size());
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
